// File: rtl/uart_rx_sampler_if.sv
// Byte delivery handshake between the UART receive front-end and the RX byte FIFO write port.
// The master drives data/valid and the slave drives ready. valid is held until ready accepts it.
interface uart_rx_sampler_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 ready;

    modport master (
        output data,
        output valid,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        output ready
    );
endinterface

// File: rtl/uart_rx_sampler.sv
// Oversampled UART receiver: synchronise rx, find start bits, majority-vote mid-bit, deliver bytes.
// Latency ~(DATA_BITS+1.5) bit times from start edge; valid held until ready, extra bytes counted as overrun.
module uart_rx_sampler #(
    parameter int DIV        = 13,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                  CLKIN,
    input  logic                  RESETN,
    input  logic                  rx,
    uart_rx_sampler_if.master     bus,
    output logic                  frame_err,
    output logic                  overrun,
    output logic                  busy
);

    localparam int M  = OVERSAMPLE / 2;
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [PW-1:0] PRE_LAST  = PW'(DIV - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] VOTE_T0   = TW'(M - 1);
    localparam logic [TW-1:0] VOTE_T1   = TW'(M);
    localparam logic [TW-1:0] VOTE_T2   = TW'(M + 1);
    localparam logic [IW-1:0] LAST_BIT  = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t state, state_nxt;

    logic                 rx_m, rx_s, rx_s_d;
    logic                 fall_edge;
    logic [PW-1:0]        presc;
    logic [TW-1:0]        tick_cnt;
    logic                 tick, sample_tick, vote_tick;
    logic [2:0]           vote;
    logic [2:0]           vote_all;
    logic                 bit_val;
    logic [IW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 hold_full;
    logic                 shift_en, load, ferr_set, ovr_set;

    assign bus.data  = data_q;
    assign bus.valid = valid_q;
    assign busy      = (state != S_IDLE);

    // rx is asynchronous to CLKIN: two flops before anything looks at it.
    always_ff @(posedge CLKIN or negedge RESETN) begin
        if (!RESETN) begin
            rx_m   <= 1'b1;
            rx_s   <= 1'b1;
            rx_s_d <= 1'b1;
        end else begin
            rx_m   <= rx;
            rx_s   <= rx_m;
            rx_s_d <= rx_s;
        end
    end

    assign fall_edge   = rx_s_d & ~rx_s;
    assign tick        = (state != S_IDLE) && (presc == PRE_LAST);
    assign sample_tick = tick && ((tick_cnt == VOTE_T0) || (tick_cnt == VOTE_T1) ||
                                  (tick_cnt == VOTE_T2));
    assign vote_tick   = tick && (tick_cnt == VOTE_T2);

    // The third sample is folded in combinationally so the decision lands on the last vote tick.
    assign vote_all = {vote[1:0], rx_s};
    assign bit_val  = (vote_all[0] & vote_all[1]) | (vote_all[0] & vote_all[2]) |
                      (vote_all[1] & vote_all[2]);

    // Prescaler and tick counter sit at zero in IDLE so every frame starts phase-aligned to its edge.
    always_ff @(posedge CLKIN or negedge RESETN) begin
        if (!RESETN) begin
            presc    <= '0;
            tick_cnt <= '0;
            vote     <= '0;
        end else begin
            if (state == S_IDLE) begin
                presc    <= '0;
                tick_cnt <= '0;
            end else begin
                presc <= (presc == PRE_LAST) ? '0 : presc + PW'(1);
                if (tick) begin
                    tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + TW'(1);
                end
            end
            if (sample_tick) begin
                vote <= vote_all;
            end
        end
    end

    always_ff @(posedge CLKIN or negedge RESETN) begin
        if (!RESETN) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // An accept in the same cycle frees the holding register before the stop-bit decision.
    assign hold_full = valid_q & ~bus.ready;

    always_comb begin
        state_nxt = state;
        shift_en  = 1'b0;
        load      = 1'b0;
        ferr_set  = 1'b0;
        ovr_set   = 1'b0;
        case (state)
            S_IDLE: begin
                if (fall_edge) begin
                    state_nxt = S_START;
                end
            end
            S_START: begin
                if (vote_tick) begin
                    state_nxt = bit_val ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (vote_tick) begin
                    shift_en = 1'b1;
                    if (bit_idx == LAST_BIT) begin
                        state_nxt = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (vote_tick) begin
                    if (bit_val) begin
                        state_nxt = S_IDLE;
                        if (hold_full) begin
                            ovr_set = 1'b1;
                        end else begin
                            load = 1'b1;
                        end
                    end else begin
                        ferr_set  = 1'b1;
                        state_nxt = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                if (rx_s) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLKIN or negedge RESETN) begin
        if (!RESETN) begin
            bit_idx   <= '0;
            shreg     <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (state == S_START) begin
                bit_idx <= '0;
            end else if (shift_en) begin
                bit_idx <= bit_idx + IW'(1);
            end
            if (shift_en) begin
                shreg[bit_idx] <= bit_val;
            end
            if (load) begin
                data_q <= shreg;
            end
            if (load) begin
                valid_q <= 1'b1;
            end else if (valid_q && bus.ready) begin
                valid_q <= 1'b0;
            end
            frame_err <= ferr_set;
            overrun   <= ovr_set;
        end
    end

    a_pulses_exclusive: assert property (@(posedge CLKIN) disable iff (!RESETN)
        !(frame_err && overrun));

    a_hold_stable: assert property (@(posedge CLKIN) disable iff (!RESETN)
        (valid_q && !bus.ready) |=> (valid_q && $stable(data_q)));

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Directed bench for uart_rx_sampler: serial frames driven on rx, byte/pulse activity logged by a monitor.
module tb_uart_rx_sampler;

    localparam int DIV = 13;
    localparam int OS  = 16;
    localparam int BIT = DIV * OS;
    localparam int BIT_FAST = 202;
    localparam int BIT_SLOW = 214;

    logic CLKIN;
    logic RESETN;
    logic rx;
    logic frame_err;
    logic overrun;
    logic busy;

    uart_rx_sampler_if #(.DATA_BITS(8)) bus ();

    uart_rx_sampler #(
        .DIV        (DIV),
        .OVERSAMPLE (OS),
        .DATA_BITS  (8)
    ) dut (
        .CLKIN     (CLKIN),
        .RESETN    (RESETN),
        .rx        (rx),
        .bus       (bus),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    int errors = 0;
    int checks = 0;

    int       acc_cnt  = 0;
    int       ferr_cyc = 0;
    int       ovr_cyc  = 0;
    int       both_cyc = 0;
    logic [7:0] acc_log [0:255];

    initial CLKIN = 1'b0;
    always #5 CLKIN = ~CLKIN;

    // Inputs change just after posedge, so mid-cycle values are what the next edge will see.
    always @(negedge CLKIN) begin
        if (bus.valid && bus.ready) begin
            acc_log[acc_cnt % 256] = bus.data;
            acc_cnt = acc_cnt + 1;
        end
        if (frame_err) ferr_cyc = ferr_cyc + 1;
        if (overrun) ovr_cyc = ovr_cyc + 1;
        if (frame_err && overrun) both_cyc = both_cyc + 1;
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge CLKIN);
            #1;
        end
    endtask

    task automatic send_bit(input logic v, input int n);
        rx = v;
        cyc(n);
    endtask

    task automatic send_byte(input logic [7:0] b, input int n, input logic stop_v);
        send_bit(1'b0, n);
        for (int i = 0; i < 8; i++) send_bit(b[i], n);
        send_bit(stop_v, n);
    endtask

    task automatic test_reset;
        RESETN = 1'b0;
        rx = 1'b1;
        bus.ready = 1'b0;
        cyc(4);
        checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.valid); end
        checks++; if (bus.data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", bus.data); end
        checks++; if ({frame_err, overrun, busy} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {frame_err, overrun, busy}); end
        RESETN = 1'b1;
        cyc(4);
    endtask

    task automatic test_single_byte;
        int a0, f0, o0;
        a0 = acc_cnt; f0 = ferr_cyc; o0 = ovr_cyc;
        bus.ready = 1'b1;
        send_byte(8'hA5, BIT, 1'b1);
        cyc(20);
        checks++; if (acc_cnt - a0 !== 1) begin errors++; $display("FAIL single_count: got %0d want 1", acc_cnt - a0); end
        checks++; if (acc_log[a0 % 256] !== 8'hA5) begin errors++; $display("FAIL single_data: got %h want a5", acc_log[a0 % 256]); end
        checks++; if ((ferr_cyc - f0) + (ovr_cyc - o0) !== 0) begin errors++; $display("FAIL single_errs: got %0d want 0", (ferr_cyc - f0) + (ovr_cyc - o0)); end
        checks++; if ({busy, bus.valid} !== 2'b00) begin errors++; $display("FAIL single_idle: got %b want 00", {busy, bus.valid}); end
    endtask

    task automatic test_back_to_back;
        int a0, o0, f0;
        a0 = acc_cnt; o0 = ovr_cyc; f0 = ferr_cyc;
        bus.ready = 1'b0;
        send_byte(8'h3C, BIT, 1'b1);
        send_byte(8'hC3, BIT, 1'b1);
        cyc(20);
        checks++; if (bus.valid !== 1'b1) begin errors++; $display("FAIL b2b_valid_held: got %b want 1", bus.valid); end
        checks++; if (bus.data !== 8'h3C) begin errors++; $display("FAIL b2b_data_held: got %h want 3c", bus.data); end
        checks++; if (ovr_cyc - o0 !== 1) begin errors++; $display("FAIL b2b_overrun: got %0d want 1", ovr_cyc - o0); end
        checks++; if (ferr_cyc - f0 !== 0) begin errors++; $display("FAIL b2b_ferr: got %0d want 0", ferr_cyc - f0); end
        bus.ready = 1'b1;
        cyc(3);
        checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL b2b_accept_valid: got %b want 0", bus.valid); end
        checks++; if (acc_cnt - a0 !== 1) begin errors++; $display("FAIL b2b_accept_count: got %0d want 1", acc_cnt - a0); end
        checks++; if (acc_log[a0 % 256] !== 8'h3C) begin errors++; $display("FAIL b2b_accept_data: got %h want 3c", acc_log[a0 % 256]); end
    endtask

    task automatic test_glitch;
        int a0, f0;
        a0 = acc_cnt; f0 = ferr_cyc;
        send_bit(1'b0, 5 * DIV);
        rx = 1'b1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_during: got %b want 1", busy); end
        cyc(300);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_after: got %b want 0", busy); end
        checks++; if ((acc_cnt - a0) + (ferr_cyc - f0) !== 0) begin errors++; $display("FAIL glitch_reports: got %0d want 0", (acc_cnt - a0) + (ferr_cyc - f0)); end
    endtask

    task automatic test_frame_error;
        int a0, f0;
        a0 = acc_cnt; f0 = ferr_cyc;
        send_byte(8'h55, BIT, 1'b0);
        send_bit(1'b0, 2 * BIT);
        checks++; if (ferr_cyc - f0 !== 1) begin errors++; $display("FAIL ferr_pulse: got %0d want 1", ferr_cyc - f0); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ferr_busy_low: got %b want 1", busy); end
        checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL ferr_valid: got %b want 0", bus.valid); end
        rx = 1'b1;
        cyc(10);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ferr_busy_release: got %b want 0", busy); end
        send_byte(8'h12, BIT, 1'b1);
        cyc(20);
        checks++; if (acc_cnt - a0 !== 1) begin errors++; $display("FAIL ferr_next_count: got %0d want 1", acc_cnt - a0); end
        checks++; if (acc_log[a0 % 256] !== 8'h12) begin errors++; $display("FAIL ferr_next_data: got %h want 12", acc_log[a0 % 256]); end
    endtask

    task automatic test_baud_skew;
        int a0;
        logic [7:0] exp_b [0:3];
        exp_b[0] = 8'h00; exp_b[1] = 8'hFF; exp_b[2] = 8'h81; exp_b[3] = 8'h81;
        a0 = acc_cnt;
        send_byte(8'h00, BIT_SLOW, 1'b1);
        cyc(30);
        send_byte(8'hFF, BIT_FAST, 1'b1);
        cyc(30);
        send_byte(8'h81, BIT_SLOW, 1'b1);
        cyc(30);
        send_byte(8'h81, BIT_FAST, 1'b1);
        cyc(30);
        checks++; if (acc_cnt - a0 !== 4) begin errors++; $display("FAIL skew_count: got %0d want 4", acc_cnt - a0); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (acc_log[(a0 + i) % 256] !== exp_b[i]) begin
                errors++;
                $display("FAIL skew_data%0d: got %h want %h", i, acc_log[(a0 + i) % 256], exp_b[i]);
            end
        end
    endtask

    task automatic test_reset_mid_frame;
        int a0;
        logic [7:0] b;
        b = 8'h7E;
        a0 = acc_cnt;
        bus.ready = 1'b0;
        send_byte(8'h66, BIT, 1'b1);
        cyc(10);
        checks++; if ({bus.valid, bus.data} !== {1'b1, 8'h66}) begin errors++; $display("FAIL rst_pre_hold: got %b/%h want 1/66", bus.valid, bus.data); end
        send_bit(1'b0, BIT);
        for (int i = 0; i < 3; i++) send_bit(b[i], BIT);
        send_bit(b[3], 100);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_pre_busy: got %b want 1", busy); end
        RESETN = 1'b0;
        rx = 1'b1;
        #1;
        checks++; if ({bus.valid, bus.data, frame_err, overrun, busy} !== 12'h000) begin
            errors++;
            $display("FAIL rst_async_clear: got %b/%h/%b%b%b want 0/00/000", bus.valid, bus.data, frame_err, overrun, busy);
        end
        cyc(5);
        RESETN = 1'b1;
        bus.ready = 1'b1;
        cyc(5);
        send_byte(8'h99, BIT, 1'b1);
        cyc(20);
        checks++; if (acc_cnt - a0 !== 1) begin errors++; $display("FAIL rst_next_count: got %0d want 1", acc_cnt - a0); end
        checks++; if (acc_log[a0 % 256] !== 8'h99) begin errors++; $display("FAIL rst_next_data: got %h want 99", acc_log[a0 % 256]); end
    endtask

    initial begin
        rx = 1'b1;
        RESETN = 1'b0;
        bus.ready = 1'b0;
        test_reset;
        test_single_byte;
        test_back_to_back;
        test_glitch;
        test_frame_error;
        test_baud_skew;
        test_reset_mid_frame;
        checks++; if (both_cyc !== 0) begin errors++; $display("FAIL pulses_overlap: got %0d want 0", both_cyc); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
